// File: rtl/ant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ant_pkg
// Description : Shared definitions for the multi-cycle core sequencer.
//               Holds the RV32 base opcodes, func3 access-width codes, the
//               sequencer state and PC-source enums, and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ant_pkg;

    // Major opcodes, instruction[6:0]
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // func3 access widths for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_JALR  = 2'b10
    } pc_src_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    // Instructions that produce a destination-register result
    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

    // Natural alignment check for loads and stores; byte accesses never fault
    function automatic logic is_misaligned(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic [1:0] a);
        logic r;
        r = 1'b0;
        if (op == OP_STORE) begin
            case (f3)
                F3_H:    r = a[0];
                F3_W:    r = (a != 2'b00);
                default: r = 1'b0;
            endcase
        end else if (op == OP_LOAD) begin
            case (f3)
                F3_H, F3_HU: r = a[0];
                F3_W:        r = (a != 2'b00);
                F3_B, F3_BU: r = 1'b0;
                default:     r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_if
// Description : Control bundle between the sequencer and the datapath /
//               memories. master = sequencer side, slave = datapath side.
//   Inputs to sequencer : opcode, func3, addr_lo, branch_taken,
//                         imem_ready, dmem_ready
//   Outputs             : imem_req, ir_load, dmem_req, dmem_we,
//                         mem_write_enable, reg_write, pc_write, pc_src,
//                         halted, trap, instret
// Revision    : 1.0 - initial release
// ============================================================================
interface core_sequencer_if;
    import ant_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [1:0]  addr_lo;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  mem_write_enable;
    logic        reg_write;
    logic        pc_write;
    pc_src_t     pc_src;
    logic        halted;
    logic        trap;
    logic [31:0] instret;

    modport master (
        input  opcode, func3, addr_lo, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_load, dmem_req, dmem_we, mem_write_enable,
               reg_write, pc_write, pc_src, halted, trap, instret
    );

    modport slave (
        output opcode, func3, addr_lo, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_load, dmem_req, dmem_we, mem_write_enable,
               reg_write, pc_write, pc_src, halted, trap, instret
    );
endinterface
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Saturating stall counter for memory handshakes.
//   clock, reset : clock and synchronous active-high reset
//   clear        : restart the run of stalled cycles
//   count_en     : current cycle is a stalled (request pending, no ready) cycle
//   expired      : current stalled cycle is the WAIT_LIMIT-th in a row
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic count_en,
    output logic      expired
);
    localparam int unsigned c_width = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [c_width-1:0] c_last = c_width'(WAIT_LIMIT - 1);

    // r_count holds the number of stalled cycles already completed, so the
    // cycle that would bring the run to WAIT_LIMIT sees r_count == c_last.
    // A ready in that same cycle deasserts count_en and is therefore a success.
    logic [c_width-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = count_en && (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control FSM: FETCH, DECODE, EXECUTE, MEM, WB,
//               HALT. Issues one-cycle IR/register/PC strobes, held memory
//               requests with byte-lane write strobes, and sticky halt/trap
//               status with a retired-instruction counter.
//   clock, reset : clock and synchronous active-high reset
//   bus          : core_sequencer_if.master control bundle
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import ant_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  wire logic        clock,
    input  wire logic        reset,
    core_sequencer_if.master bus
);

    seq_state_t  r_state;
    logic        r_halted;
    logic        r_trap;
    logic [31:0] r_instret;

    logic        w_imem_req;
    logic        w_ir_load;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic [3:0]  w_mem_we;
    logic        w_reg_write;
    logic        w_pc_write;
    pc_src_t     w_pc_src;
    logic [3:0]  w_lane_mask;
    logic        w_is_mem_op;
    logic        w_stall;
    logic        w_expired;

    assign w_is_mem_op = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);

    // A stall is a pending request with no ready. Any non-stalled cycle
    // restarts the run, which covers every state change.
    assign w_stall = !reset &&
                     (((r_state == S_FETCH) && !bus.imem_ready) ||
                      ((r_state == S_MEM)   && !bus.dmem_ready));

    wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!w_stall),
        .count_en (w_stall),
        .expired  (w_expired)
    );

    // Byte-lane strobes for stores
    always_comb begin
        w_lane_mask = 4'b0000;
        case (bus.func3)
            F3_B:    w_lane_mask = 4'b0001 << bus.addr_lo;
            F3_H:    w_lane_mask = 4'b0011 << bus.addr_lo;
            F3_W:    w_lane_mask = 4'b1111;
            default: w_lane_mask = 4'b0000;
        endcase
    end

    // Strobes and requests are decoded from the registered state and live
    // inputs; reset forces them all low so nothing fires while it is held.
    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_load   = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_mem_we    = 4'b0000;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = PC_PLUS4;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_imem_req = 1'b1;
                    w_ir_load  = bus.imem_ready;
                end
                S_MEM: begin
                    w_dmem_req = 1'b1;
                    if (bus.opcode == OP_STORE) begin
                        w_dmem_we = 1'b1;
                        w_mem_we  = w_lane_mask;
                    end
                end
                S_WB: begin
                    w_pc_write  = 1'b1;
                    w_reg_write = writes_rd(bus.opcode);
                    if ((bus.opcode == OP_JAL) ||
                        ((bus.opcode == OP_BRANCH) && bus.branch_taken)) begin
                        w_pc_src = PC_IMM;
                    end else if (bus.opcode == OP_JALR) begin
                        w_pc_src = PC_JALR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_trap    <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_expired) begin
                        r_trap  <= 1'b1;
                        r_state <= S_HALT;
                    end
                end
                S_DECODE: begin
                    if (!is_legal_op(bus.opcode)) begin
                        r_trap  <= 1'b1;
                        r_state <= S_HALT;
                    end else if (bus.opcode == OP_SYSTEM) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    // Alignment is resolved here so a faulting access never
                    // raises dmem_req.
                    if (w_is_mem_op) begin
                        if (is_misaligned(bus.opcode, bus.func3, bus.addr_lo)) begin
                            r_trap  <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_MEM;
                        end
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        r_state <= S_WB;
                    end else if (w_expired) begin
                        r_trap  <= 1'b1;
                        r_state <= S_HALT;
                    end
                end
                S_WB: begin
                    r_instret <= r_instret + 32'd1;
                    r_state   <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_trap  <= 1'b1;
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign bus.imem_req         = w_imem_req;
    assign bus.ir_load          = w_ir_load;
    assign bus.dmem_req         = w_dmem_req;
    assign bus.dmem_we          = w_dmem_we;
    assign bus.mem_write_enable = w_mem_we;
    assign bus.reg_write        = w_reg_write;
    assign bus.pc_write         = w_pc_write;
    assign bus.pc_src           = w_pc_src;
    assign bus.halted           = r_halted;
    assign bus.trap             = r_trap;
    assign bus.instret          = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer. A table of directed
//               instruction vectors is replayed cycle by cycle, followed by
//               hand-written fault, timeout, halt and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;
    import ant_pkg::*;

    logic clock = 1'b0;
    logic reset;

    core_sequencer_if bus();

    core_sequencer #(
        .WAIT_LIMIT (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [1:0] addr_lo;
        logic       taken;
        int         dwait;    // dmem stall cycles before ready
        int         lat;      // cycle index of WB (FETCH = cycle 1)
        logic       rw;
        logic [1:0] pc_src;
        int         mem_cyc;  // cycles with dmem_req high
        logic       we;
        logic [3:0] mask;
    } vec_t;

    localparam int c_nvec = 16;
    vec_t vecs [c_nvec];

    int n_checks = 0;
    int n_errors = 0;
    int exp_instret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_bits();
        return 32'({bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we,
                    bus.mem_write_enable, bus.reg_write, bus.pc_write, bus.pc_src});
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    // Entered in the FETCH cycle of the instruction; returns in its WB cycle.
    task automatic run_vec(input int i);
        int   cyc;
        int   mem_cyc;
        logic done;
        bus.opcode       = vecs[i].opcode;
        bus.func3        = vecs[i].func3;
        bus.addr_lo      = vecs[i].addr_lo;
        bus.branch_taken = vecs[i].taken;
        bus.imem_ready   = 1'b1;
        bus.dmem_ready   = 1'b0;
        #1;
        cyc     = 1;
        mem_cyc = 0;
        done    = 1'b0;
        check($sformatf("v%0d req+ir_load c1", i), {bus.imem_req, bus.ir_load}, 2'b11);
        while (!done) begin
            if (bus.dmem_req) begin
                mem_cyc++;
                check($sformatf("v%0d dmem_we", i), bus.dmem_we, vecs[i].we);
                check($sformatf("v%0d mem_write_enable", i), bus.mem_write_enable, vecs[i].mask);
                bus.dmem_ready = (mem_cyc > vecs[i].dwait);
            end else begin
                bus.dmem_ready = 1'b0;
            end
            #1;
            if (bus.pc_write) begin
                done = 1'b1;
                check($sformatf("v%0d wb cycle", i), cyc, vecs[i].lat);
                check($sformatf("v%0d reg_write", i), bus.reg_write, vecs[i].rw);
                check($sformatf("v%0d pc_src", i), bus.pc_src, vecs[i].pc_src);
                check($sformatf("v%0d dmem_req cycles", i), mem_cyc, vecs[i].mem_cyc);
            end else begin
                check($sformatf("v%0d stray reg_write c%0d", i, cyc), bus.reg_write, 1'b0);
                if (cyc >= 40) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL v%0d wb timeout: got no pc_write, expected one by cycle %0d", i, vecs[i].lat);
                    done = 1'b1;
                end else begin
                    next_cycle();
                    cyc++;
                end
            end
        end
        exp_instret++;
    endtask

    task automatic reset_pulse(input string tag);
        next_cycle();
        reset = 1'b1;
        #1;
        check({tag, " outputs during reset"}, busy_bits(), 32'd0);
        next_cycle();
        check({tag, " trap after reset"}, bus.trap, 1'b0);
        check({tag, " halted after reset"}, bus.halted, 1'b0);
        check({tag, " instret after reset"}, bus.instret, 32'd0);
        reset = 1'b0;
        exp_instret = 0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int   n;
        logic saw_req;

        //           opcode     f3     addr  tk  dw lat rw  pc     mc we  mask
        vecs[0]  = '{OP_OP,     F3_B, 2'b00, 1'b0, 0,  4, 1'b1, 2'b00, 0, 1'b0, 4'b0000};
        vecs[1]  = '{OP_STORE,  F3_B, 2'b10, 1'b0, 3,  8, 1'b0, 2'b00, 4, 1'b1, 4'b0100};
        vecs[2]  = '{OP_BRANCH, F3_B, 2'b00, 1'b1, 0,  4, 1'b0, 2'b01, 0, 1'b0, 4'b0000};
        vecs[3]  = '{OP_BRANCH, F3_B, 2'b00, 1'b0, 0,  4, 1'b0, 2'b00, 0, 1'b0, 4'b0000};
        vecs[4]  = '{OP_JAL,    F3_B, 2'b00, 1'b0, 0,  4, 1'b1, 2'b01, 0, 1'b0, 4'b0000};
        vecs[5]  = '{OP_JALR,   F3_B, 2'b00, 1'b0, 0,  4, 1'b1, 2'b10, 0, 1'b0, 4'b0000};
        vecs[6]  = '{OP_LOAD,   F3_W, 2'b00, 1'b0, 0,  5, 1'b1, 2'b00, 1, 1'b0, 4'b0000};
        vecs[7]  = '{OP_STORE,  F3_H, 2'b10, 1'b0, 1,  6, 1'b0, 2'b00, 2, 1'b1, 4'b1100};
        vecs[8]  = '{OP_STORE,  F3_W, 2'b00, 1'b0, 0,  5, 1'b0, 2'b00, 1, 1'b1, 4'b1111};
        vecs[9]  = '{OP_LUI,    F3_B, 2'b00, 1'b0, 0,  4, 1'b1, 2'b00, 0, 1'b0, 4'b0000};
        vecs[10] = '{OP_FENCE,  F3_B, 2'b00, 1'b0, 0,  4, 1'b0, 2'b00, 0, 1'b0, 4'b0000};
        vecs[11] = '{OP_LOAD,   F3_H, 2'b10, 1'b0, 2,  7, 1'b1, 2'b00, 3, 1'b0, 4'b0000};
        vecs[12] = '{OP_STORE,  F3_B, 2'b11, 1'b0, 0,  5, 1'b0, 2'b00, 1, 1'b1, 4'b1000};
        vecs[13] = '{OP_LOAD,   F3_W, 2'b00, 1'b0, 15, 20, 1'b1, 2'b00, 16, 1'b0, 4'b0000};
        vecs[14] = '{OP_IMM,    F3_B, 2'b00, 1'b1, 0,  4, 1'b1, 2'b00, 0, 1'b0, 4'b0000};
        vecs[15] = '{OP_AUIPC,  F3_B, 2'b00, 1'b0, 0,  4, 1'b1, 2'b00, 0, 1'b0, 4'b0000};

        reset            = 1'b1;
        bus.opcode       = OP_OP;
        bus.func3        = F3_B;
        bus.addr_lo      = 2'b00;
        bus.branch_taken = 1'b0;
        bus.imem_ready   = 1'b1;
        bus.dmem_ready   = 1'b0;

        // Reset state, with imem_ready high to show no request leaks out
        repeat (3) @(posedge clock);
        #2;
        check("reset outputs", busy_bits(), 32'd0);
        check("reset halted", bus.halted, 1'b0);
        check("reset trap", bus.trap, 1'b0);
        check("reset instret", bus.instret, 32'd0);
        reset = 1'b0;

        // Table-driven instruction sequence, back to back
        for (int i = 0; i < c_nvec; i++) begin
            if (i != 0) begin
                next_cycle();
                check($sformatf("v%0d instret before", i), bus.instret, exp_instret);
            end
            run_vec(i);
        end
        next_cycle();
        check("instret after table", bus.instret, exp_instret);

        // Misaligned LW: trap without ever raising dmem_req
        bus.opcode  = OP_LOAD;
        bus.func3   = F3_W;
        bus.addr_lo = 2'b01;
        #1;
        saw_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.dmem_req) saw_req = 1'b1;
            next_cycle();
        end
        check("misaligned no dmem_req", saw_req, 1'b0);
        check("misaligned trap", bus.trap, 1'b1);
        check("misaligned halted", bus.halted, 1'b0);
        check("misaligned halt outputs", busy_bits(), 32'd0);
        check("misaligned instret", bus.instret, exp_instret);
        reset_pulse("rst1");

        // Illegal opcode traps right after DECODE
        bus.opcode  = 7'b1111111;
        bus.addr_lo = 2'b00;
        #1;
        check("illegal fetch c1", bus.imem_req, 1'b1);
        next_cycle();
        check("illegal trap in decode", bus.trap, 1'b0);
        next_cycle();
        check("illegal trap after decode", bus.trap, 1'b1);
        check("illegal halt outputs", busy_bits(), 32'd0);

        // Fetch timeout: 16 unanswered FETCH cycles then trap
        bus.imem_ready = 1'b0;
        reset_pulse("rst2");
        n = 0;
        while (bus.imem_req && (n < 40)) begin
            n++;
            next_cycle();
        end
        check("timeout fetch cycles", n, 16);
        check("timeout trap", bus.trap, 1'b1);
        check("timeout halt outputs", busy_bits(), 32'd0);
        repeat (3) next_cycle();
        check("timeout halt absorbing", busy_bits(), 32'd0);
        reset_pulse("rst3");
        check("fetch resumes after reset", bus.imem_req, 1'b1);

        // EBREAK: halted set, instret frozen
        run_vec(0);
        next_cycle();
        check("pre-ebreak instret", bus.instret, 32'd1);
        bus.opcode = OP_SYSTEM;
        #1;
        next_cycle();
        next_cycle();
        check("ebreak halted", bus.halted, 1'b1);
        check("ebreak trap", bus.trap, 1'b0);
        check("ebreak halt outputs", busy_bits(), 32'd0);
        repeat (3) next_cycle();
        check("ebreak instret frozen", bus.instret, 32'd1);
        check("ebreak halted sticky", bus.halted, 1'b1);
        reset_pulse("rst4");

        // Reset while a data request is stalled
        bus.opcode     = OP_LOAD;
        bus.func3      = F3_W;
        bus.addr_lo    = 2'b00;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        #1;
        n = 0;
        while (!bus.dmem_req && (n < 10)) begin
            n++;
            next_cycle();
        end
        check("mid-wait dmem_req up", bus.dmem_req, 1'b1);
        next_cycle();
        next_cycle();
        check("mid-wait dmem_req held", bus.dmem_req, 1'b1);
        reset = 1'b1;
        next_cycle();
        check("mid-wait dmem_req after reset", bus.dmem_req, 1'b0);
        check("mid-wait outputs after reset", busy_bits(), 32'd0);
        reset = 1'b0;
        #1;
        check("mid-wait fetch resumes", bus.imem_req, 1'b1);
        check("mid-wait trap clear", bus.trap, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the processor's fetch, decode, execute, memory and writeback phases. It takes the opcode and func3 from the decoder and status from the datapath and memories, and issues one-cycle register, PC and instruction-register enables and held memory requests. It replaces the free-running per-cycle `reg_write` with phase-gated strobes. This lets instruction and data memory have variable latency and gives the core a defined halt/trap path.

## Interface
- `WAIT_LIMIT`, default 16: maximum cycles a memory request may stay unanswered before a trap.
- `clock` in 1: single clock; everything is registered on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: instruction[6:0], from the decoder.
- `func3` in 3: from the decoder.
- `addr_lo` in 2: data address bits [1:0], from the datapath ALU.
- `branch_taken` in 1: branch comparison result, from the datapath.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `ir_load` out 1: latch the instruction register.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write.
- `mem_write_enable` out 4: byte-lane write strobes.
- `reg_write` out 1: register file write strobe.
- `pc_write` out 1: PC update strobe.
- `pc_src` out 2: PC source select; 00 = pc+4, 01 = pc+imm, 10 = jalr target.
- `halted` out 1: sticky; set by ECALL/EBREAK.
- `trap` out 1: sticky; set by an illegal opcode, a misaligned access or a wait timeout.
- `instret` out 32: retired-instruction counter.

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- **FETCH:**
  - `imem_req`=1 while in this state.
  - On `imem_ready`: pulse `ir_load`, go to DECODE.
- **DECODE** (1 cycle): classify `opcode`.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
  - Any other opcode: set `trap`, go to HALT.
  - SYSTEM: set `halted`, go to HALT.
  - All others: go to EXECUTE.
- **EXECUTE** (1 cycle): LOAD and STORE go to MEM; all others go to WB.
- **MEM:**
  - `dmem_req`=1 while in this state; `dmem_we`=1 for STORE.
  - `mem_write_enable` for STORE:
    - SB: 0001<<`addr_lo`.
    - SH: 0011<<`addr_lo`.
    - SW: 1111.
  - `mem_write_enable` is 0000 for LOAD.
  - Misalignment (checked on MEM entry, before any request is issued): SH with `addr_lo[0]`=1, or SW/LW with `addr_lo`≠00, or LH/LHU with `addr_lo[0]`=1. Response: set `trap`, go to HALT, no `dmem_req`.
  - On `dmem_ready`: go to WB.
- **WB** (1 cycle):
  - `pc_write`=1.
  - `reg_write`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - `pc_src`:
    - 01 for JAL, and for BRANCH with `branch_taken`.
    - 10 for JALR.
    - 00 otherwise.
  - `instret`+=1 (wraps modulo 2^32).
  - Next state: FETCH.
- **HALT:** absorbing; all strobes and requests 0; left only by `reset`.
- **Wait timer:**
  - Counts consecutive cycles in FETCH without `imem_ready`, or in MEM without `dmem_ready`.
  - Reaching `WAIT_LIMIT` sets `trap` and goes to HALT.
  - Cleared on every state change.
- **Simultaneous events:** `ready` on the same cycle the count reaches `WAIT_LIMIT` counts as success, no trap.

## Timing
- **Reset values:** state=FETCH, all strobes/requests 0, `pc_src`=00, `mem_write_enable`=0000, `halted`=0, `trap`=0, `instret`=0, wait timer 0.
- `imem_req` goes high the first cycle after reset deasserts.
- **Outputs:** decoded combinationally from the registered state plus the current inputs. `ir_load`, `reg_write` and `pc_write` are single-cycle pulses.
- **Request handshake:**
  - `imem_req`/`dmem_req` stay high until the matching `ready` is sampled high.
  - A `ready` arriving while no request is pending is ignored.
- **Minimum latency (zero-wait memory):**
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - LOAD/STORE: 5 cycles.
  - Each memory wait cycle adds 1.
- **Reset mid-request:** the request drops on the cycle after `reset` is sampled. No strobe fires during reset.

## Structure
- Shared package `ant_pkg` holds:
  - Opcode constants (`OP_LUI` … `OP_SYSTEM`).
  - `seq_state_t` enum.
  - `pc_src_t` enum.
  - func3 width constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Natural sub-module: `wait_timer`. It is a saturating counter with `clear`, `count_en` and `expired` (count == `WAIT_LIMIT`).
- The byte-lane mask stays as inline combinational logic.

## Test plan
- **ADD, zero-wait memory:** `imem_ready`=1 constantly, opcode=0110011.
  - `ir_load` in cycle 1; `reg_write`=`pc_write`=1 with `pc_src`=00 in cycle 4.
  - `instret`=1; next `imem_req` in cycle 5.
- **SB:** opcode=0100011, func3=000, `addr_lo`=10, `dmem_ready` asserted after 3 wait cycles.
  - `mem_write_enable`=0100 and `dmem_we`=1, held 4 cycles.
  - Then WB with `reg_write`=0.
- **BEQ:** run once with `branch_taken`=1, then once with `branch_taken`=0.
  - Taken: `pc_src`=01 in WB. Not taken: `pc_src`=00.
  - `reg_write`=0 both times.
- **Faults:**
  - LW with `addr_lo`=01: `trap`=1, no `dmem_req` ever asserted, state HALT.
  - opcode=1111111: `trap`=1 after DECODE.
- **Timeout:** `WAIT_LIMIT`=16, `imem_ready` held 0.
  - `trap` set after 16 FETCH cycles; all outputs 0 afterwards.
  - `reset` pulse: `trap`=0, `instret`=0, FETCH resumes.
- **EBREAK and reset mid-wait:**
  - opcode=1110011: `halted`=1, `instret` frozen.
  - `reset` asserted mid-MEM wait: `dmem_req` low the next cycle.
